// File: rtl/morse_encoder_pkg.sv
// Shared types and constants for the Morse keying encoder.
package morse_pkg;

  localparam int LEN_W  = 3;
  localparam int PAT_W  = 6;
  localparam int CNT_W  = 24;

  localparam int EGAP_U = 1;
  localparam int CGAP_U = 3;
  localparam int WORD_U = 4;
  localparam int DASH_U = 3;

  // A length of zero marks a byte with no Morse code
  localparam logic [LEN_W-1:0] LEN_UNSUP = '0;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    EGAP,
    CGAP,
    WORD
  } state_e;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pat;
  } code_t;

endpackage

// File: rtl/morse_encoder_if.sv
// Character handshake between a text source and the Morse encoder.
interface morse_encoder_if;
  logic [7:0] iDATA;
  logic       iVALID;
  logic       oREADY;

  modport master (output iDATA, output iVALID, input oREADY);
  modport slave  (input iDATA, input iVALID, output oREADY);
endinterface

// File: rtl/morse_encoder_rom.sv
// ASCII to Morse code lookup; patterns are left-aligned, 1 = dash.
// MORSE_ENC_PUNCT_EN adds . , ? / = to the table.
module morse_rom
  import morse_pkg::*;
(
  input  logic [7:0] char_i,
  output code_t      code_o,
  output logic       space_o
);

  logic [7:0] upper;

  always_comb begin
    upper = char_i;
    if (char_i >= 8'h61 && char_i <= 8'h7A) upper = char_i - 8'h20;
  end

  always_comb begin
    code_o  = '{len: LEN_UNSUP, pat: '0};
    space_o = (char_i == 8'h20);
    case (upper)
      "A": code_o = '{3'd2, 6'b010000};
      "B": code_o = '{3'd4, 6'b100000};
      "C": code_o = '{3'd4, 6'b101000};
      "D": code_o = '{3'd3, 6'b100000};
      "E": code_o = '{3'd1, 6'b000000};
      "F": code_o = '{3'd4, 6'b001000};
      "G": code_o = '{3'd3, 6'b110000};
      "H": code_o = '{3'd4, 6'b000000};
      "I": code_o = '{3'd2, 6'b000000};
      "J": code_o = '{3'd4, 6'b011100};
      "K": code_o = '{3'd3, 6'b101000};
      "L": code_o = '{3'd4, 6'b010000};
      "M": code_o = '{3'd2, 6'b110000};
      "N": code_o = '{3'd2, 6'b100000};
      "O": code_o = '{3'd3, 6'b111000};
      "P": code_o = '{3'd4, 6'b011000};
      "Q": code_o = '{3'd4, 6'b110100};
      "R": code_o = '{3'd3, 6'b010000};
      "S": code_o = '{3'd3, 6'b000000};
      "T": code_o = '{3'd1, 6'b100000};
      "U": code_o = '{3'd3, 6'b001000};
      "V": code_o = '{3'd4, 6'b000100};
      "W": code_o = '{3'd3, 6'b011000};
      "X": code_o = '{3'd4, 6'b100100};
      "Y": code_o = '{3'd4, 6'b101100};
      "Z": code_o = '{3'd4, 6'b110000};
      "0": code_o = '{3'd5, 6'b111110};
      "1": code_o = '{3'd5, 6'b011110};
      "2": code_o = '{3'd5, 6'b001110};
      "3": code_o = '{3'd5, 6'b000110};
      "4": code_o = '{3'd5, 6'b000010};
      "5": code_o = '{3'd5, 6'b000000};
      "6": code_o = '{3'd5, 6'b100000};
      "7": code_o = '{3'd5, 6'b110000};
      "8": code_o = '{3'd5, 6'b111000};
      "9": code_o = '{3'd5, 6'b111100};
`ifdef MORSE_ENC_PUNCT_EN
      ".": code_o = '{3'd6, 6'b010101};
      ",": code_o = '{3'd6, 6'b110011};
      "?": code_o = '{3'd6, 6'b001100};
      "/": code_o = '{3'd5, 6'b100100};
      "=": code_o = '{3'd5, 6'b100010};
`endif
      default: code_o = '{len: LEN_UNSUP, pat: '0};
    endcase
  end

endmodule

// File: rtl/morse_encoder.sv
// Keys ASCII characters onto a single Morse mark/space line.
// The IDLE cycle doubles as the last cycle of each gap, so held input keys back-to-back with exact gaps.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 12_500_000
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  morse_encoder_if.slave bus,
  output logic           oKEY,
  output logic           oBUSY
);

  localparam logic [CNT_W-1:0] UNIT_LAST  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] UNIT_SHORT = CNT_W'(UNIT_CYCLES - 2);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       unit_q, unit_d;
  logic             key_q, ready_q, busy_q;

  code_t rom_code;
  logic  rom_space;
  logic  xfer, unit_end, phase_end, short_last;
  logic  [1:0] phase_units;

  morse_rom u_rom (
    .char_i  (bus.iDATA),
    .code_o  (rom_code),
    .space_o (rom_space)
  );

  assign xfer = bus.iVALID && ready_q;

  always_comb begin
    phase_units = 2'd0;
    short_last  = 1'b0;
    case (state_q)
      MARK: phase_units = pat_q[PAT_W-1] ? 2'(DASH_U - 1) : 2'd0;
      EGAP: phase_units = 2'(EGAP_U - 1);
      CGAP: begin
        phase_units = 2'(CGAP_U - 1);
        short_last  = 1'b1;
      end
      WORD: begin
        phase_units = 2'(WORD_U - 1);
        short_last  = 1'b1;
      end
      default: phase_units = 2'd0;
    endcase
  end

  // Gap phases end one cycle early; the following IDLE cycle completes them
  assign unit_end  = (cnt_q == UNIT_LAST);
  assign phase_end = (unit_q == phase_units) &&
                     (cnt_q == (short_last ? UNIT_SHORT : UNIT_LAST));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q + CNT_W'(1);
    unit_d  = unit_q;
    if (phase_end) begin
      cnt_d  = '0;
      unit_d = '0;
    end else if (unit_end) begin
      cnt_d  = '0;
      unit_d = unit_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        unit_d = '0;
        if (xfer) begin
          if (rom_space) begin
            state_d = WORD;
          end else if (rom_code.len != LEN_UNSUP) begin
            state_d = MARK;
            len_d   = rom_code.len;
            pat_d   = rom_code.pat;
          end
        end
      end
      MARK: if (phase_end) begin
        len_d   = len_q - LEN_W'(1);
        state_d = (len_q == LEN_W'(1)) ? CGAP : EGAP;
      end
      EGAP: if (phase_end) begin
        pat_d   = pat_q << 1;
        state_d = MARK;
      end
      CGAP, WORD: if (phase_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      len_q   <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      unit_q  <= '0;
      key_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      unit_q  <= unit_d;
      key_q   <= (state_q == MARK);
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.oREADY = ready_q;
  assign oKEY       = key_q;
  assign oBUSY      = busy_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: per-cycle reference model of the key line plus directed timing checks.
module tb_morse_encoder;
  localparam int U = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key, busy;

  morse_encoder_if bus();

  morse_encoder #(.UNIT_CYCLES(U)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus),
    .oKEY   (key),
    .oBUSY  (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Dot/dash spelling of each supported character
  function automatic string code_of(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
`ifdef MORSE_ENC_PUNCT_EN
      ".": return ".-.-.-"; ",": return "--..--"; "?": return "..--..";
      "/": return "-..-.";  "=": return "-...-";
`endif
      default: return "";
    endcase
  endfunction

  // Expected key waveform (one bit per cycle) for a character; empty if discarded
  bit seq_tmp[$];
  function automatic void make_seq(input logic [7:0] c);
    string s;
    seq_tmp.delete();
    if (c == 8'h20) begin
      repeat (4 * U) seq_tmp.push_back(1'b0);
      return;
    end
    s = code_of(c);
    for (int i = 0; i < s.len(); i++) begin
      repeat (((s[i] == "-") ? 3 : 1) * U) seq_tmp.push_back(1'b1);
      repeat (((i == s.len() - 1) ? 3 : 1) * U) seq_tmp.push_back(1'b0);
    end
  endfunction

  bit model_q[$];
  int rem_m = 0;
  bit key_m = 1'b0;
  bit rdy_m = 1'b1;
  bit hs_m;
  bit live = 1'b0;

  always @(posedge clk) begin
    live = 1'b1;
    if (!rst_n) begin
      model_q.delete();
      rem_m = 0;
      key_m = 1'b0;
      rdy_m = 1'b1;
    end else begin
      hs_m  = bus.iVALID && rdy_m;
      key_m = (model_q.size() > 0) ? model_q.pop_front() : 1'b0;
      if (rem_m > 0) rem_m--;
      if (hs_m) begin
        make_seq(bus.iDATA);
        if (seq_tmp.size() > 0) begin
          foreach (seq_tmp[i]) model_q.push_back(seq_tmp[i]);
          rem_m = seq_tmp.size() - 1;
        end
      end
      rdy_m = (rem_m == 0);
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("cyc_key", key, key_m);
      check("cyc_ready", bus.oREADY, rdy_m);
      check("cyc_busy", busy, !rdy_m);
    end
  end

  logic cap[$];
  int   runs[$];

  task automatic capture(input int n);
    cap.delete();
    repeat (n) begin
      @(negedge clk);
      cap.push_back(key);
    end
  endtask

  function automatic void get_runs();
    int   cnt;
    logic cur;
    bit   started;
    runs.delete();
    cnt = 0; cur = 1'b0; started = 1'b0;
    foreach (cap[i]) begin
      if (!started) begin
        if (cap[i]) begin
          started = 1'b1; cur = 1'b1; cnt = 1;
        end
      end else if (cap[i] == cur) begin
        cnt++;
      end else begin
        runs.push_back(cnt);
        cur = cap[i];
        cnt = 1;
      end
    end
    if (started) runs.push_back(cnt);
  endfunction

  function automatic int run_at(input int k);
    return (k < runs.size()) ? runs[k] : -1;
  endfunction

  // Leaves iVALID high so a following send keeps the stream back-to-back
  task automatic send(input logic [7:0] c);
    int guard;
    guard = 0;
    bus.iDATA  = c;
    bus.iVALID = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.oREADY && guard < 500);
    check("hs_wait_ready", bus.oREADY, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.iVALID = 1'b0;
    repeat (n) begin
      bus.iDATA = 8'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  int exp_a[4] = '{4, 4, 12, 12};
`ifdef MORSE_ENC_PUNCT_EN
  int exp_p[11] = '{4, 4, 12, 4, 4, 4, 12, 4, 4, 4, 12};
`endif

  initial begin
    int prev, rises, guard, sel, k;
    logic [7:0] c;
    string letters;
    letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789 .,?/=";

    bus.iVALID = 1'b0;
    bus.iDATA  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_key", key, 0);
    check("rst_ready", bus.oREADY, 1);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    make_seq("a");
    cap.delete();
    foreach (seq_tmp[i]) cap.push_back(seq_tmp[i]);
    get_runs();
    check("model_a_nruns", runs.size(), 4);
    for (int i = 0; i < 4; i++) check("model_a_run", run_at(i), exp_a[i]);

    send("E"); idle(0);
    capture(20);
    check("E_key_at_hs", cap[0], 0);
    check("E_key_hs_plus1", cap[1], 1);
    get_runs();
    check("E_high", run_at(0), 4);

    idle(20);
    fork
      begin send("E"); send("E"); idle(0); end
      capture(60);
    join
    get_runs();
    check("EE_gap", run_at(1), 12);
    check("EE_second_high", run_at(2), 4);

    idle(30);
    send("a"); idle(0);
    capture(40);
    get_runs();
    check("a_run0", run_at(0), 4);
    check("a_run1", run_at(1), 4);
    check("a_run2", run_at(2), 12);

    idle(30);
    fork
      begin send("S"); send(" "); send("O"); idle(0); end
      capture(150);
    join
    get_runs();
    check("SO_last_S_mark", run_at(4), 4);
    check("SO_word_gap", run_at(5), 28);
    check("SO_first_O_mark", run_at(6), 12);

    idle(70);
    send(8'h2E); idle(0);
`ifdef MORSE_ENC_PUNCT_EN
    capture(90);
    get_runs();
    for (int i = 0; i < 11; i++) check("punct_run", run_at(i), exp_p[i]);
    check("punct_tail_low", run_at(11) >= 12, 1);
`else
    @(negedge clk);
    check("unsup_ready", bus.oREADY, 1);
    check("unsup_key", key, 0);
    capture(8);
    get_runs();
    check("unsup_no_mark", runs.size(), 0);
`endif

    idle(60);
    send("0"); idle(0);
    prev = 0; rises = 0; guard = 0;
    while (rises < 2 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (key && !prev) rises++;
      prev = key;
    end
    check("zero_second_mark_seen", rises, 2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_key", key, 0);
    check("midrst_ready", bus.oREADY, 1);
    check("midrst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send("T"); idle(0);
    capture(30);
    get_runs();
    check("T_high", run_at(0), 12);
    check("T_low", run_at(1) >= 12, 1);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8) c = letters[$urandom_range(0, letters.len() - 1)];
      else c = 8'($urandom);
      send(c);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 10));
      if (i == 30) begin
        idle($urandom_range(5, 40));
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
      end
    end
    idle(0);

    guard = 0;
    while (!bus.oREADY && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("final_ready", bus.oREADY, 1);
    k = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + k);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/morse_encoder.md
# morse_encoder

Character-to-keying stage feeding the Morse tone/beacon stage. Accepts ASCII bytes over a valid/ready handshake and looks up each character's Morse code. Emits a single key line (`oKEY`: 1 = mark, 0 = space) with standard dot/dash/gap timing in unit periods. The downstream tone stage gates its audio carrier with `oKEY`; this replaces the hard-wired duration table with arbitrary text.

## Interface
- `UNIT_CYCLES`, default 12_500_000: clock cycles per Morse unit. The default gives 250 ms at 50 MHz. Legal range is 2 to 2^24−1.
- `iCLK` in 1: system clock. All logic is on the rising edge.
- `iRST_N` in 1: reset, synchronous and active-low.
- `iDATA` in 8: ASCII character. Sampled only on handshake.
- `iVALID` in 1: `iDATA` is valid.
- `oREADY` out 1: the block can accept a character.
- `oKEY` out 1: keyed output, registered.
- `oBUSY` out 1: a character is being keyed; high in every state except IDLE.

## Operation
- Handshake: a transfer occurs on a rising edge where `iVALID && oREADY`.
  - `oREADY` = (state == IDLE), and is registered.
  - `iDATA` may change freely when no transfer occurs.
- Lookup:
  - `A`–`Z` and `a`–`z` map case-insensitively to the ITU codes.
  - `0`–`9` map to the ITU 5-element codes.
  - Space (0x20) is a word gap.
  - Every other byte is accepted and discarded.
  - Each code is stored as len (3 bits, 1–6) plus pattern (6 bits, MSB-first, 1 = dash).
- Element timing, in units:
  - dot mark = 1
  - dash mark = 3
  - gap between elements within a character = 1
  - character gap after the last element = 3
  - space = 4 units off; this produces 7 units total after a preceding character
- State machine:
  - IDLE: `oKEY`=0, ready. On a handshake with a valid character, load len/pattern and go to MARK. On a space, go to WORD. On an unsupported byte, stay in IDLE with `oREADY` held high, so no cycle is lost.
  - MARK: `oKEY`=1 for 1 or 3 units. Decrement the element count. Go to EGAP if elements remain, otherwise go to CGAP.
  - EGAP: `oKEY`=0 for 1 unit, then return to MARK with the pattern shifted left.
  - CGAP: `oKEY`=0 for 3 units, then go to IDLE.
  - WORD: `oKEY`=0 for 4 units, then go to IDLE.
- Unit counter:
  - 24 bits.
  - Cleared on every state entry.
  - A unit ends when the count reaches UNIT_CYCLES−1.
  - A separate 2-bit unit counter times the 3- and 4-unit phases.
- Reset, including mid-character: on the next edge, state=IDLE, `oKEY`=0, `oREADY`=1, `oBUSY`=0, and all counters are 0. A partially keyed character is abandoned.

## Timing
- Reset values: `oKEY`=0, `oREADY`=1, `oBUSY`=0.
- Handshake on edge t:
  - `oKEY`=1, `oREADY`=0 and `oBUSY`=1 are visible after edge t+1.
  - For a space, `oKEY` stays 0.
- Durations are exact: every mark or gap of n units lasts n·UNIT_CYCLES cycles, with no extra cycles between phases.
- Character duration:
  - character total = (Σmarks + (len−1) + 3)·UNIT_CYCLES cycles from the first `oKEY` high to `oREADY` high.
  - Example: `E` = 4·UNIT_CYCLES.
  - Back-to-back characters therefore have an exact 3-unit gap, provided `iVALID` is held.
- Space duration: 4·UNIT_CYCLES cycles from the handshake to `oREADY`.
- An unsupported byte costs zero cycles; `oREADY` never drops.

## Configuration
- `MORSE_ENC_PUNCT_EN`:
  - When defined, these punctuation codes are added:
    - `.` = .-.-.-
    - `,` = --..--
    - `?` = ..--..
    - `/` = -..-.
    - `=` = -...-
  - When undefined, these bytes are unsupported and are discarded as above.
- The 6-bit pattern width and 3-bit length field are the same in both builds.

## Structure
- Package `morse_pkg` holds:
  - the state enum (IDLE, MARK, EGAP, CGAP, WORD)
  - width constants: LEN_W=3, PAT_W=6
  - gap-length constants: EGAP_U=1, CGAP_U=3, WORD_U=4, DASH_U=3
  - the encoding of the "unsupported" marker (len=0)
- Sub-module `morse_rom` is a purely combinational ASCII → {len, pattern} lookup. It contains the `MORSE_ENC_PUNCT_EN` guard. The FSM, unit counter and handshake stay in `morse_encoder`.

## Test plan
All scenarios run with UNIT_CYCLES=4.
- Send `E` (0x45):
  - `oKEY` is high for exactly 4 cycles starting at handshake+1.
  - `oKEY` is then low for 12 cycles, after which `oREADY` goes high.
- Send `a` (0x61):
  - key pattern is 4 high, 4 low, 12 high, 12 low.
  - `oREADY` returns 32 cycles after the first `oKEY` rise.
- Send `S`, space, `O` back-to-back with `iVALID` held:
  - the gap between the last `S` mark and the first `O` mark is exactly 28 cycles (7 units).
- Send 0x2E with `MORSE_ENC_PUNCT_EN` undefined:
  - the handshake completes, `oREADY` stays 1 and `oKEY` stays 0.
- Repeat with `MORSE_ENC_PUNCT_EN` defined:
  - pattern is 1, 1, 3, 1, 1, 1, 3, 1, 1, 1, 3, 3 units, alternating high and low.
- Assert `iRST_N`=0 during the second mark of `0`:
  - on the next edge `oKEY`=0, `oREADY`=1 and `oBUSY`=0.
  - After release, `T` keys as 12 high then 12 low.
